// File: rtl/fetch_buffer_stage.sv
// N-wide fetch stage: sequential icache requests feeding a circular fetch queue drained by dispatch.
// Optional perf counters are enabled by defining FETCH_PERF_CNT_EN.
package fetch_pkg;
    localparam int XLEN = 32;

    typedef struct packed {
        logic            valid;
        logic [31:0]     inst;
        logic [XLEN-1:0] npc;
        logic [XLEN-1:0] pc;
    } IF_ID_PACKET;
endpackage

module fetch_buffer_stage
    import fetch_pkg::*;
#(
    parameter int              WIDTH    = 3,
    parameter int              DEPTH    = 8,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic                                clock,
    input  logic                                reset,
    input  logic [WIDTH-1:0][31:0]              cache_data,
    input  logic [WIDTH-1:0]                    cache_valid,
    input  logic                                take_branch,
    input  logic [XLEN-1:0]                     target_pc,
    input  logic [$clog2(WIDTH+1)-1:0]          dispatch_num,
    output logic [WIDTH-1:0][XLEN-1:0]          proc2Icache_addr,
    output IF_ID_PACKET [WIDTH-1:0]             if_packet_out,
    output logic [$clog2(DEPTH+1)-1:0]          buf_count,
    output logic                                buf_full
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]                         perf_fetched,
    output logic [31:0]                         perf_stall_full,
    output logic [31:0]                         perf_stall_miss
`endif
);

    localparam int CNT_W = $clog2(DEPTH+1);
    localparam int NUM_W = $clog2(WIDTH+1);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [XLEN-1:0]  pc;
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [CNT_W-1:0] count;

    logic [XLEN-1:0]  pc_mem   [DEPTH];
    logic [31:0]      inst_mem [DEPTH];

    logic [NUM_W-1:0] hit_len;
    logic             hit_run;
    logic [CNT_W-1:0] free;
    logic [CNT_W-1:0] accept_raw;
    logic [CNT_W-1:0] deq_raw;
    logic [CNT_W-1:0] accept;
    logic [CNT_W-1:0] deq;

    // Only the contiguous run of hits from slot 0 is usable; later hits are dropped.
    always_comb begin
        hit_len = '0;
        hit_run = 1'b1;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (hit_run && cache_valid[i]) begin
                hit_len = hit_len + NUM_W'(1);
            end else begin
                hit_run = 1'b0;
            end
        end
    end

    always_comb begin
        free       = CNT_W'(DEPTH) - count;
        accept_raw = (CNT_W'(hit_len) < free) ? CNT_W'(hit_len) : free;
        deq_raw    = (CNT_W'(dispatch_num) < count) ? CNT_W'(dispatch_num) : count;
        accept     = take_branch ? '0 : accept_raw;
        deq        = take_branch ? '0 : deq_raw;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pc    <= RESET_PC;
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (take_branch) begin
            pc    <= target_pc & ~XLEN'(3);
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            assert (accept <= free);
            assert (deq <= count);
            pc    <= pc + (XLEN'(accept) << 2);
            tail  <= PTR_W'((32'(tail) + 32'(accept)) % DEPTH);
            head  <= PTR_W'((32'(head) + 32'(deq)) % DEPTH);
            count <= count + accept - deq;
        end
    end

    // Storage carries no reset; unoccupied entries are masked on the output side.
    always_ff @(posedge clock) begin
        if (!reset && !take_branch) begin
            for (int unsigned i = 0; i < WIDTH; i++) begin
                if (CNT_W'(i) < accept) begin
                    pc_mem[PTR_W'((32'(tail) + i) % DEPTH)]   <= pc + XLEN'(4 * i);
                    inst_mem[PTR_W'((32'(tail) + i) % DEPTH)] <= cache_data[i];
                end
            end
        end
    end

    always_comb begin
        if_packet_out = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            proc2Icache_addr[i] = pc + XLEN'(4 * i);
            if (CNT_W'(i) < count) begin
                if_packet_out[i].valid = 1'b1;
                if_packet_out[i].inst  = inst_mem[PTR_W'((32'(head) + i) % DEPTH)];
                if_packet_out[i].pc    = pc_mem[PTR_W'((32'(head) + i) % DEPTH)];
                if_packet_out[i].npc   = pc_mem[PTR_W'((32'(head) + i) % DEPTH)] + XLEN'(4);
            end
        end
    end

    assign buf_count = count;
    assign buf_full  = (count == CNT_W'(DEPTH));

`ifdef FETCH_PERF_CNT_EN
    function automatic logic [31:0] sat_add(input logic [31:0] v, input logic [31:0] inc);
        logic [32:0] s;
        s = {1'b0, v} + {1'b0, inc};
        return s[32] ? '1 : s[31:0];
    endfunction

    always_ff @(posedge clock) begin
        if (reset) begin
            perf_fetched    <= '0;
            perf_stall_full <= '0;
            perf_stall_miss <= '0;
        end else begin
            perf_fetched    <= sat_add(perf_fetched, 32'(accept));
            perf_stall_full <= sat_add(perf_stall_full,
                                       32'((hit_len != '0) && (free == '0)));
            perf_stall_miss <= sat_add(perf_stall_miss,
                                       32'(!cache_valid[0] && !take_branch));
        end
    end
`endif

endmodule
